// File: rtl/jtframe_obj_linedraw_pkg.sv
// rtl/jtframe_obj_linedraw_pkg.sv - shared constants and FSM encoding for the object line drawer
package jtframe_obj_linedraw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DRAW = 2'd3
  } state_t;

  localparam int          PXL_W        = 4;
  localparam int          PXL_PER_WORD = 8;
  localparam logic [3:0]  PXL_TRANSP   = 4'd0;

endpackage

// File: rtl/jtframe_obj_pxlsel.sv
// rtl/jtframe_obj_pxlsel.sv - nibble selector with horizontal flip and transparency flag
module jtframe_obj_pxlsel
  import jtframe_obj_linedraw_pkg::*;
(
  input  logic [PXL_W*PXL_PER_WORD-1:0] word,
  input  logic [2:0]                    k,
  input  logic                          hflip,
  output logic [PXL_W-1:0]              pixel,
  output logic                          opaque
);

  logic [2:0] idx;

  // Flipping walks the word from the top nibble down: 7-k is simply ~k on 3 bits
  assign idx    = hflip ? ~k : k;
  assign pixel  = word[{idx, 2'b00} +: PXL_W];
  assign opaque = pixel != PXL_TRANSP;

endmodule

// File: rtl/jtframe_obj_linedraw.sv
// rtl/jtframe_obj_linedraw.sv - draws one 16-pixel 4bpp object row into the line buffer
module jtframe_obj_linedraw
  import jtframe_obj_linedraw_pkg::*;
#(
  parameter int AW = 9,
  parameter int CW = 12,
  parameter int PW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw,
  output logic              busy,
  input  logic [CW-1:0]     code,
  input  logic [AW-1:0]     xpos,
  input  logic [3:0]        ysub,
  input  logic              hflip,
  input  logic              vflip,
  input  logic [PW-1:0]     pal,
  output logic [CW+4:0]     rom_addr,
  output logic              rom_cs,
  input  logic              rom_ok,
  input  logic [31:0]       rom_data,
  output logic [AW-1:0]     buf_addr,
  output logic [PW+3:0]     buf_din,
  output logic              buf_we
);

  state_t          state, state_nxt;
  logic [CW-1:0]   code_q;
  logic [AW-1:0]   xpos_q;
  logic [3:0]      row_q;
  logic            hflip_q;
  logic [PW-1:0]   pal_q;
  logic            half_q;
  logic            second;
  logic            wait_first;
  logic [2:0]      k;
  logic [31:0]     word_q;
  logic [3:0]      pixel;
  logic            opaque;

  jtframe_obj_pxlsel u_pxlsel (
    .word   (word_q),
    .k      (k),
    .hflip  (hflip_q),
    .pixel  (pixel),
    .opaque (opaque)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (draw && !busy) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: if (!wait_first && rom_ok) state_nxt = DRAW;
      DRAW: if (k == 3'd7) state_nxt = second ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_din    <= '0;
      code_q     <= '0;
      xpos_q     <= '0;
      row_q      <= '0;
      hflip_q    <= 1'b0;
      pal_q      <= '0;
      half_q     <= 1'b0;
      second     <= 1'b0;
      wait_first <= 1'b0;
      k          <= '0;
      word_q     <= '0;
    end else begin
      state  <= state_nxt;
      buf_we <= 1'b0;
      case (state)
        IDLE: begin
          // busy lingers one cycle past the last DRAW so the final write lands first
          if (busy) begin
            busy <= 1'b0;
          end else if (draw) begin
            busy    <= 1'b1;
            code_q  <= code;
            xpos_q  <= xpos;
            row_q   <= vflip ? ~ysub : ysub;
            hflip_q <= hflip;
            pal_q   <= pal;
            half_q  <= hflip;
            second  <= 1'b0;
          end
        end
        REQ: begin
          rom_cs     <= 1'b1;
          rom_addr   <= {code_q, row_q, half_q};
          wait_first <= 1'b1;
        end
        WAIT: begin
          wait_first <= 1'b0;
          // the first WAIT cycle may still show data for the previous address
          if (!wait_first && rom_ok) begin
            word_q <= rom_data;
            rom_cs <= 1'b0;
            k      <= '0;
          end
        end
        DRAW: begin
          buf_we   <= opaque;
          buf_addr <= xpos_q + AW'({second, k});
          buf_din  <= {pal_q, pixel};
          k        <= k + 3'd1;
          if (k == 3'd7 && !second) begin
            second <= 1'b1;
            half_q <= ~half_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
